// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand-fetch sequencer ahead of a single-read-port register file
//
// Purpose:
//   Accepts a two-source request and reads the register file twice through
//   its single read port (srcA first, then srcB). The two operands are then
//   held for the execute stage under a valid/ready handshake. The register
//   file write port is snooped so that captured and held operands always
//   match the register file contents.
//
// Ports:
//   clk       in   1      clock, rising edge
//   reset     in   1      synchronous, active-high
//   reqValid  in   1      request present on srcA/srcB
//   reqReady  out  1      request accepted this cycle
//   srcA      in   ADDR   first source register address
//   srcB      in   ADDR   second source register address
//   readAddr  out  ADDR   register file read address
//   dOut      in   WIDTH  register file read data (combinational)
//   wbEnable  in   1      register file write enable (snooped)
//   wbAddr    in   ADDR   register file write address (snooped)
//   wbData    in   WIDTH  register file write data (snooped)
//   opValid   out  1      opA/opB valid for execute stage
//   opReady   in   1      execute stage accepts operands
//   opA       out  WIDTH  operand from srcA
//   opB       out  WIDTH  operand from srcB

module operand_fetch #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [ADDR-1:0]  srcA,
  input  logic [ADDR-1:0]  srcB,
  output logic [ADDR-1:0]  readAddr,
  input  logic [WIDTH-1:0] dOut,
  input  logic             wbEnable,
  input  logic [ADDR-1:0]  wbAddr,
  input  logic [WIDTH-1:0] wbData,
  output logic             opValid,
  input  logic             opReady,
  output logic [WIDTH-1:0] opA,
  output logic [WIDTH-1:0] opB
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ_A = 2'd1;
  localparam logic [1:0] S_READ_B = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]       r_state;
  logic [ADDR-1:0]  r_addrA;
  logic [ADDR-1:0]  r_addrB;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;

  logic             w_accept;
  logic             w_hitA;
  logic             w_hitB;
  logic [WIDTH-1:0] w_fwdA;
  logic [WIDTH-1:0] w_fwdB;

  // A new request can be taken while idle, or in HOLD on the same edge the
  // execute stage consumes the current pair (back-to-back operation).
  assign reqReady = (r_state == S_IDLE) || ((r_state == S_HOLD) && opReady);
  assign w_accept = reqValid && reqReady;

  // Driven only from registered addresses so the read port never sees
  // glitches from the request inputs.
  assign readAddr = (r_state == S_READ_B) ? r_addrB : r_addrA;

  assign opValid = (r_state == S_HOLD);
  assign opA     = r_opA;
  assign opB     = r_opB;

  // Write-through bypass: a write landing on the same edge as the capture
  // is not yet visible on dOut, so take the write data directly.
  assign w_hitA = wbEnable && (wbAddr == r_addrA);
  assign w_hitB = wbEnable && (wbAddr == r_addrB);
  assign w_fwdA = w_hitA ? wbData : dOut;
  assign w_fwdB = w_hitB ? wbData : dOut;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addrA <= '0;
      r_addrB <= '0;
      r_opA   <= '0;
      r_opB   <= '0;
    end else begin
      if (w_accept) begin
        r_addrA <= srcA;
        r_addrB <= srcB;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_READ_A;
          end
        end

        S_READ_A: begin
          r_opA   <= w_fwdA;
          r_state <= S_READ_B;
        end

        S_READ_B: begin
          r_opB <= w_fwdB;
          // opA was captured last cycle; keep it coherent with a write now.
          if (w_hitA) begin
            r_opA <= wbData;
          end
          r_state <= S_HOLD;
        end

        S_HOLD: begin
          // Snoop against the addresses of the pair being held. On the exit
          // edge the update is harmless because the pair is discarded.
          if (w_hitA) begin
            r_opA <= wbData;
          end
          if (w_hitB) begin
            r_opB <= wbData;
          end
          if (opReady) begin
            r_state <= w_accept ? S_READ_A : S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

  logic       clk;
  logic       reset;
  logic       reqValid;
  logic       reqReady;
  logic [1:0] srcA;
  logic [1:0] srcB;
  logic [1:0] readAddr;
  logic [7:0] dOut;
  logic       wbEnable;
  logic [1:0] wbAddr;
  logic [7:0] wbData;
  logic       opValid;
  logic       opReady;
  logic [7:0] opA;
  logic [7:0] opB;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rf [4];

  operand_fetch #(.WIDTH(8), .ADDR(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .srcA     (srcA),
    .srcB     (srcB),
    .readAddr (readAddr),
    .dOut     (dOut),
    .wbEnable (wbEnable),
    .wbAddr   (wbAddr),
    .wbData   (wbData),
    .opValid  (opValid),
    .opReady  (opReady),
    .opA      (opA),
    .opB      (opB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: r0..r3 = 0..3 after reset, combinational read.
  always @(posedge clk) begin
    if (reset) begin
      rf[0] <= 8'd0;
      rf[1] <= 8'd1;
      rf[2] <= 8'd2;
      rf[3] <= 8'd3;
    end else if (wbEnable) begin
      rf[wbAddr] <= wbData;
    end
  end

  assign dOut = rf[readAddr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    reset    = 1'b1;
    reqValid = 1'b0;
    opReady  = 1'b0;
    wbEnable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Starts at a negedge with the block idle. Optional write during READ_A.
  // With do_exit=0 it returns at the first HOLD negedge, opReady low.
  task automatic fetch_pair(input string tag, input logic [1:0] a, input logic [1:0] b,
                            input logic wen, input logic [1:0] waddr, input logic [7:0] wdata,
                            input logic [7:0] ea, input logic [7:0] eb, input logic do_exit);
    reqValid = 1'b1;
    srcA     = a;
    srcB     = b;
    opReady  = 1'b0;
    @(negedge clk);
    check_eq({tag, "_rdA_addr"}, readAddr, a);
    check_eq({tag, "_rdA_ready"}, reqReady, 1'b0);
    check_eq({tag, "_rdA_valid"}, opValid, 1'b0);
    reqValid = 1'b0;
    srcA     = ~a;
    srcB     = ~b;
    if (wen) begin
      wbEnable = 1'b1;
      wbAddr   = waddr;
      wbData   = wdata;
    end
    @(negedge clk);
    wbEnable = 1'b0;
    check_eq({tag, "_rdB_addr"}, readAddr, b);
    check_eq({tag, "_rdB_opA"}, opA, ea);
    check_eq({tag, "_rdB_valid"}, opValid, 1'b0);
    @(negedge clk);
    check_eq({tag, "_hold_valid"}, opValid, 1'b1);
    check_eq({tag, "_hold_opA"}, opA, ea);
    check_eq({tag, "_hold_opB"}, opB, eb);
    check_eq({tag, "_hold_ready"}, reqReady, 1'b0);
    if (do_exit) begin
      opReady = 1'b1;
      #1;
      check_eq({tag, "_hold_ready_hi"}, reqReady, 1'b1);
      @(negedge clk);
      opReady = 1'b0;
      check_eq({tag, "_idle_valid"}, opValid, 1'b0);
      check_eq({tag, "_idle_ready"}, reqReady, 1'b1);
    end
  endtask

  initial begin
    reset    = 1'b1;
    reqValid = 1'b0;
    srcA     = 2'd0;
    srcB     = 2'd0;
    wbEnable = 1'b0;
    wbAddr   = 2'd0;
    wbData   = 8'd0;
    opReady  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", opValid, 1'b0);
    check_eq("rst_ready", reqReady, 1'b1);
    check_eq("rst_addr", readAddr, 2'd0);
    check_eq("rst_opA", opA, 8'd0);
    check_eq("rst_opB", opB, 8'd0);
    reset = 1'b0;
    @(negedge clk);

    // T1: plain fetch
    fetch_pair("t1", 2'd1, 2'd2, 1'b0, 2'd0, 8'd0, 8'd1, 8'd2, 1'b1);

    // T2: write r1 during READ_A is bypassed into opA
    fetch_pair("t2", 2'd1, 2'd3, 1'b1, 2'd1, 8'hAA, 8'hAA, 8'd3, 1'b1);

    // T3: stall in HOLD, snoop write to r2 updates opB
    fetch_pair("t3", 2'd0, 2'd2, 1'b0, 2'd0, 8'd0, 8'd0, 8'd2, 1'b0);
    @(negedge clk);
    check_eq("t3_h1_valid", opValid, 1'b1);
    check_eq("t3_h1_opB", opB, 8'd2);
    @(negedge clk);
    check_eq("t3_h2_valid", opValid, 1'b1);
    wbEnable = 1'b1;
    wbAddr   = 2'd2;
    wbData   = 8'h55;
    @(negedge clk);
    wbEnable = 1'b0;
    check_eq("t3_h3_valid", opValid, 1'b1);
    check_eq("t3_h3_opA", opA, 8'd0);
    check_eq("t3_h3_opB", opB, 8'h55);
    @(negedge clk);
    check_eq("t3_h4_valid", opValid, 1'b1);
    check_eq("t3_h4_opB", opB, 8'h55);
    opReady = 1'b1;
    @(negedge clk);
    opReady = 1'b0;
    check_eq("t3_idle_valid", opValid, 1'b0);

    // T4: back-to-back with opReady and reqValid held high
    pulse_reset();
    opReady  = 1'b1;
    reqValid = 1'b1;
    srcA     = 2'd0;
    srcB     = 2'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("t4_%0d_rdA_valid", k), opValid, 1'b0);
      check_eq($sformatf("t4_%0d_rdA_addr", k), readAddr, (k == 0) ? 2'd0 : (k == 1) ? 2'd2 : 2'd3);
      if (k == 0) begin
        srcA = 2'd2;
        srcB = 2'd3;
      end else if (k == 1) begin
        srcA = 2'd3;
        srcB = 2'd0;
      end else begin
        reqValid = 1'b0;
      end
      @(negedge clk);
      check_eq($sformatf("t4_%0d_rdB_valid", k), opValid, 1'b0);
      @(negedge clk);
      check_eq($sformatf("t4_%0d_hold_valid", k), opValid, 1'b1);
      check_eq($sformatf("t4_%0d_opA", k), opA, (k == 0) ? 8'd0 : (k == 1) ? 8'd2 : 8'd3);
      check_eq($sformatf("t4_%0d_opB", k), opB, (k == 0) ? 8'd1 : (k == 1) ? 8'd3 : 8'd0);
    end
    @(negedge clk);
    opReady = 1'b0;
    check_eq("t4_idle_valid", opValid, 1'b0);
    check_eq("t4_idle_ready", reqReady, 1'b1);

    // T5: reset during READ_B aborts the fetch
    reqValid = 1'b1;
    srcA     = 2'd1;
    srcB     = 2'd2;
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    check_eq("t5_rdB_opA", opA, 8'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_valid", opValid, 1'b0);
    check_eq("t5_rst_opA", opA, 8'd0);
    check_eq("t5_rst_opB", opB, 8'd0);
    check_eq("t5_rst_ready", reqReady, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t5_post_valid", opValid, 1'b0);
    fetch_pair("t5", 2'd1, 2'd1, 1'b0, 2'd0, 8'd0, 8'd1, 8'd1, 1'b1);

    // T6: same source twice, write during HOLD updates both operands
    fetch_pair("t6", 2'd3, 2'd3, 1'b0, 2'd0, 8'd0, 8'd3, 8'd3, 1'b0);
    wbEnable = 1'b1;
    wbAddr   = 2'd3;
    wbData   = 8'hF0;
    @(negedge clk);
    wbEnable = 1'b0;
    check_eq("t6_valid", opValid, 1'b1);
    check_eq("t6_opA", opA, 8'hF0);
    check_eq("t6_opB", opB, 8'hF0);
    opReady = 1'b1;
    @(negedge clk);
    opReady = 1'b0;
    check_eq("t6_idle_valid", opValid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
